fetch_sequencer: RTL and testbench

Program-counter and fetch controller that drives the 16-bit instruction ROM and delivers instructions to decode.
- Generates the ROM address (pco).
- Tracks the ROM's 1-cycle registered read latency.
- Buffers returned instructions in a 2-entry skid FIFO behind a valid/ready handshake.
- Handles redirects (branch/jump) with squash, and halts at the end of ROM.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_skid_fifo.sv | 48 ++++
 rtl/fetch_sequencer.sv | 82 ++++++++
 tb/tb_fetch_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer
package fetch_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int FIFO_DEPTH = 2;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry {pc,data} skid FIFO, flush beats push, push+pop same cycle allowed
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_data,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_data
);
  logic [ADDR_W-1:0] pc_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic              deq;
  logic [1:0]        wr;
  assign deq       = pop && count != 2'd0;
  assign wr        = count - {1'b0, deq};
  assign head_pc   = pc_q[0];
  assign head_data = data_q[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      pc_q   <= '{default: '0};
      data_q <= '{default: '0};
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, deq};
      if (deq) begin
        pc_q[0]   <= pc_q[1];
        data_q[0] <= data_q[1];
      end
      if (push) begin
        pc_q[wr[0]]   <= push_pc;
        data_q[wr[0]] <= push_data;
      end
    end
  end
  assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !deq && count == 2'(FIFO_DEPTH)));
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC generation, ROM latency tracking, skid buffering and redirect handling
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ROM_DEPTH = 100,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] pco_out,
  input  logic [DATA_W-1:0] rom_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              halted,
  output logic              addr_err
);
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(ROM_DEPTH);
  localparam logic [ADDR_W-1:0] PC0   = ADDR_W'(RESET_PC);
  state_t            state;
  logic [ADDR_W-1:0] next_pc, pco_q, inflight_pc;
  logic [1:0]        count;
  logic              inflight, issue, pop, redir, bad, done;
  assign pop    = instr_valid & instr_ready;
  assign redir  = redirect_valid && state != IDLE;
  assign bad    = redirect_pc >= DEPTH;
  // credit counts the in-flight return so the FIFO can always absorb it
  assign issue  = state == RUN && !redir && next_pc < DEPTH &&
                  (3'(count) + 3'(inflight) - 3'(pop)) < 3'(FIFO_DEPTH);
  assign pco_out = issue ? next_pc : pco_q;
  assign done   = next_pc >= DEPTH && !inflight &&
                  (count == 2'd0 || (count == 2'd1 && pop));
  assign busy   = state == RUN;
  assign halted = state == HALT;
  assign instr_valid = count != 2'd0;
  fetch_skid_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight & !redir),
    .pop       (pop),
    .flush     (redir),
    .push_pc   (inflight_pc),
    .push_data (rom_instr),
    .count     (count),
    .head_pc   (instr_pc),
    .head_data (instr_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      next_pc     <= PC0;
      pco_q       <= PC0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      addr_err    <= 1'b0;
    end else begin
      pco_q    <= pco_out;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= next_pc;
        next_pc     <= next_pc + 1'b1;
      end
      if (redir) begin
        next_pc  <= redirect_pc;
        state    <= bad ? HALT : RUN;
        addr_err <= addr_err | bad;
      end else if (state == IDLE && start) begin
        state   <= RUN;
        next_pc <= PC0;
      end else if (state == RUN && done) begin
        state <= HALT;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench with an identity ROM (word n = n)
module tb_fetch_sequencer;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [15:0] pco_out;
  logic [15:0] rom_instr = '0;
  logic        redirect_valid = 0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 0;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        busy, halted, addr_err;
  int          total = 0;
  int          bad = 0;
  int          pco_max = 0;
  int          q[$];

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pco_out(pco_out), .rom_instr(rom_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .busy(busy), .halted(halted), .addr_err(addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_instr <= pco_out;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && int'(pco_out) > pco_max) pco_max = int'(pco_out);
    if (instr_valid && instr_ready) begin
      if (q.size() == 0) chk("unexpected_instr", int'(instr_pc), -1);
      else begin
        int e;
        e = q.pop_front();
        chk("instr_data", int'(instr_data), e);
        chk("instr_pc", int'(instr_pc), e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) q.push_back(i);
  endtask

  task automatic restart();
    rst = 1;
    tick();
    rst = 0;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_pc(input int pc);
    int n = 0;
    while (!(instr_valid && int'(instr_pc) == pc) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("wait_pc_timeout", int'(instr_pc), pc);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    chk("drain_left", q.size(), 0);
    chk("end_halted", int'(halted), 1);
    chk("end_busy", int'(busy), 0);
    chk("end_valid", int'(instr_valid), 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid", int'(instr_valid), 0);
    chk("rst_pco", int'(pco_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_addr_err", int'(addr_err), 0);
    chk("rst_data", int'(instr_data), 0);
    chk("rst_pc", int'(instr_pc), 0);
    // full run with ready high, latency and end-of-ROM halt
    instr_ready = 1;
    expect_range(0, 99);
    restart();
    chk("e0_pco", int'(pco_out), 0);
    chk("e0_busy", int'(busy), 1);
    chk("e0_valid", int'(instr_valid), 0);
    tick();
    chk("e1_valid", int'(instr_valid), 0);
    tick();
    chk("e2_valid", int'(instr_valid), 1);
    drain();
    // stall while pc 10 is presented
    expect_range(0, 99);
    restart();
    wait_pc(10);
    instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", int'(instr_valid), 1);
      chk("stall_data", int'(instr_data), 10);
    end
    instr_ready = 1;
    drain();
    // redirect coinciding with transfer of 7
    expect_range(0, 7);
    expect_range(50, 99);
    restart();
    wait_pc(7);
    redirect_valid = 1;
    redirect_pc = 50;
    tick();
    redirect_valid = 0;
    chk("redir_valid_after", int'(instr_valid), 0);
    drain();
    // out-of-range redirect then recovery
    expect_range(0, 3);
    restart();
    wait_pc(3);
    redirect_valid = 1;
    redirect_pc = 120;
    tick();
    redirect_valid = 0;
    chk("bad_addr_err", int'(addr_err), 1);
    chk("bad_halted", int'(halted), 1);
    chk("bad_valid", int'(instr_valid), 0);
    tick();
    tick();
    tick();
    chk("bad_valid_later", int'(instr_valid), 0);
    expect_range(5, 99);
    redirect_valid = 1;
    redirect_pc = 5;
    tick();
    redirect_valid = 0;
    chk("resume_busy", int'(busy), 1);
    chk("resume_addr_err", int'(addr_err), 1);
    drain();
    chk("sticky_addr_err", int'(addr_err), 1);
    // reset mid-run
    expect_range(0, 30);
    restart();
    wait_pc(30);
    rst = 1;
    start = 1;
    tick();
    chk("mrst_valid", int'(instr_valid), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_pco", int'(pco_out), 0);
    chk("mrst_addr_err", int'(addr_err), 0);
    chk("mrst_q", q.size(), 0);
    tick();
    rst = 0;
    start = 0;
    tick();
    chk("idle_busy", int'(busy), 0);
    expect_range(0, 99);
    start = 1;
    tick();
    start = 0;
    chk("restart_busy", int'(busy), 1);
    drain();
    chk("pco_max", pco_max, 99);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
